rect_compositor: RTL and testbench

- Renders up to `NUM_OBJ` filled rectangles (ball, paddles, net, score blocks) into the VGA pixel stream.
- Sits between the game-logic blocks and the `vga` generator; its `pixel` output drives `vga.pixel_rgb`.
- Generalises the single-rectangle renderer:
  - per-object colour, enable and priority;
  - frame-synchronous shadowing of object positions, so there is no tearing;
  - a registered 2-stage compare pipeline;
  - per-frame collision flags between object 0 (ball) and every other object.

---
 rtl/vga_pkg.sv | 18 +
 rtl/rect_compositor_if.sv | 31 +++
 rtl/rect_hit.sv | 74 +++++++
 rtl/rect_compositor.sv | 92 +++++++++
 tb/tb_rect_compositor.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared raster constants and named colours
// for the VGA pixel path.
package vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int DEF_COLOR_W = 3;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

endpackage

// File: rtl/rect_compositor_if.sv
// rect_compositor_if: object descriptors from game logic
// and collision results returned to it.
interface rect_compositor_if #(
  parameter int NUM_OBJ = 4,
  parameter int COORD_W = 11,
  parameter int SIZE_W  = 10,
  parameter int COLOR_W = 3
);

  logic [NUM_OBJ*COORD_W-1:0] obj_x;
  logic [NUM_OBJ*COORD_W-1:0] obj_y;
  logic [NUM_OBJ*SIZE_W-1:0]  obj_w;
  logic [NUM_OBJ*SIZE_W-1:0]  obj_h;
  logic [NUM_OBJ*COLOR_W-1:0] obj_color;
  logic [NUM_OBJ-1:0]         obj_en;
  logic [NUM_OBJ-1:0]         coll_flags;
  logic                       coll_valid;

  modport master (
    output obj_x, obj_y, obj_w, obj_h,
    output obj_color, obj_en,
    input  coll_flags, coll_valid
  );

  modport slave (
    input  obj_x, obj_y, obj_w, obj_h,
    input  obj_color, obj_en,
    output coll_flags, coll_valid
  );

endinterface

// File: rtl/rect_hit.sv
// rect_hit: frame-shadowed geometry of one rectangle
// and its registered stage-1 coverage test.
module rect_hit #(
  parameter int COORD_W = 11,
  parameter int SIZE_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_frame_tick,
  input  logic               i_pixel_tick,
  input  logic [9:0]         i_hpos,
  input  logic [9:0]         i_vpos,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [SIZE_W-1:0]  i_w,
  input  logic [SIZE_W-1:0]  i_h,
  input  logic               i_en,
  output logic               o_hit
);

  localparam int AW = COORD_W + 1;
  localparam logic signed [AW-1:0] ONE = AW'(1);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [SIZE_W-1:0]  r_w;
  logic [SIZE_W-1:0]  r_h;
  logic               r_en;

  logic signed [AW-1:0] w_px;
  logic signed [AW-1:0] w_py;
  logic signed [AW-1:0] w_x0;
  logic signed [AW-1:0] w_y0;
  logic signed [AW-1:0] w_x1;
  logic signed [AW-1:0] w_y1;
  logic                 w_in;

  // one extra bit keeps x+w-1 from wrapping
  assign w_px = {{(AW-10){1'b0}}, i_hpos};
  assign w_py = {{(AW-10){1'b0}}, i_vpos};
  assign w_x0 = {r_x[COORD_W-1], r_x};
  assign w_y0 = {r_y[COORD_W-1], r_y};
  assign w_x1 = w_x0
    + $signed({{(AW-SIZE_W){1'b0}}, r_w}) - ONE;
  assign w_y1 = w_y0
    + $signed({{(AW-SIZE_W){1'b0}}, r_h}) - ONE;

  assign w_in = r_en && (|r_w) && (|r_h)
    && (w_px >= w_x0) && (w_px <= w_x1)
    && (w_py >= w_y0) && (w_py <= w_y1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_w   <= '0;
      r_h   <= '0;
      r_en  <= 1'b0;
      o_hit <= 1'b0;
    end else begin
      if (i_frame_tick) begin
        r_x  <= i_x;
        r_y  <= i_y;
        r_w  <= i_w;
        r_h  <= i_h;
        r_en <= i_en;
      end
      if (i_pixel_tick) begin
        o_hit <= w_in;
      end
    end
  end

endmodule

// File: rtl/rect_compositor.sv
// rect_compositor: draws NUM_OBJ prioritised rectangles
// into the pixel stream and flags ball collisions.
module rect_compositor
  import vga_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int COORD_W = 11,
  parameter int SIZE_W  = 10,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pixel_tick,
  input  logic               frame_tick,
  input  logic               active,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  rect_compositor_if.slave   gl,
  output logic [COLOR_W-1:0] pixel
);

  localparam logic [NUM_OBJ-1:0] BALL = NUM_OBJ'(1);

  logic [NUM_OBJ-1:0]         w_hit;
  logic [COLOR_W-1:0]         w_color;
  logic [NUM_OBJ*COLOR_W-1:0] r_color;
  logic [COLOR_W-1:0]         r_pixel;
  logic                       r_act_d;
  logic [NUM_OBJ-1:0]         r_acc;
  logic [NUM_OBJ-1:0]         r_coll_flags;
  logic                       r_coll_valid;

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
    rect_hit #(
      .COORD_W (COORD_W),
      .SIZE_W  (SIZE_W)
    ) u_hit (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_tick (frame_tick),
      .i_pixel_tick (pixel_tick),
      .i_hpos       (hpos),
      .i_vpos       (vpos),
      .i_x          (gl.obj_x[i*COORD_W +: COORD_W]),
      .i_y          (gl.obj_y[i*COORD_W +: COORD_W]),
      .i_w          (gl.obj_w[i*SIZE_W +: SIZE_W]),
      .i_h          (gl.obj_h[i*SIZE_W +: SIZE_W]),
      .i_en         (gl.obj_en[i]),
      .o_hit        (w_hit[i])
    );
  end

  // lowest index wins: scan downwards so it lands last
  always_comb begin
    w_color = BG_COLOR;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_color = r_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_color      <= '0;
      r_pixel      <= '0;
      r_act_d      <= 1'b0;
      r_acc        <= '0;
      r_coll_flags <= '0;
      r_coll_valid <= 1'b0;
    end else begin
      r_coll_valid <= frame_tick;
      if (frame_tick) begin
        r_color      <= gl.obj_color;
        r_coll_flags <= r_acc;
        r_acc        <= '0;
      end else if (pixel_tick && r_act_d && w_hit[0]) begin
        r_acc <= r_acc | (w_hit & ~BALL);
      end
      if (pixel_tick) begin
        r_act_d <= active;
        r_pixel <= r_act_d ? w_color : '0;
      end
    end
  end

  assign pixel         = r_pixel;
  assign gl.coll_flags = r_coll_flags;
  assign gl.coll_valid = r_coll_valid;

endmodule

// File: tb/tb_rect_compositor.sv
// tb_rect_compositor: randomised raster stimulus checked
// against a painter's-rule model of the compositor.
module tb_rect_compositor;
  import vga_pkg::*;

  localparam int N  = 4;
  localparam int CW = 11;
  localparam int SW = 10;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pixel_tick = 1'b0;
  logic          frame_tick = 1'b0;
  logic          active = 1'b0;
  logic [9:0]    hpos = '0;
  logic [9:0]    vpos = '0;
  logic [KW-1:0] pixel;

  rect_compositor_if #(
    .NUM_OBJ (N),
    .COORD_W (CW),
    .SIZE_W  (SW),
    .COLOR_W (KW)
  ) gl ();

  rect_compositor #(
    .NUM_OBJ  (N),
    .COORD_W  (CW),
    .SIZE_W   (SW),
    .COLOR_W  (KW),
    .BG_COLOR (COL_BLACK)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_tick (pixel_tick),
    .frame_tick (frame_tick),
    .active     (active),
    .hpos       (hpos),
    .vpos       (vpos),
    .gl         (gl),
    .pixel      (pixel)
  );

  always #5 clk = ~clk;

  // live object descriptors driven by the bench
  int lx[N];
  int ly[N];
  int lw[N];
  int lh[N];
  int lc[N];
  bit le[N];

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign gl.obj_x[g*CW +: CW]     = lx[g][CW-1:0];
    assign gl.obj_y[g*CW +: CW]     = ly[g][CW-1:0];
    assign gl.obj_w[g*SW +: SW]     = lw[g][SW-1:0];
    assign gl.obj_h[g*SW +: SW]     = lh[g][SW-1:0];
    assign gl.obj_color[g*KW +: KW] = lc[g][KW-1:0];
    assign gl.obj_en[g]             = le[g];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, got, exp);
    end
  endtask

  // model state: shadowed objects, expected outputs
  int sx[N];
  int sy[N];
  int sw[N];
  int sh[N];
  int sc[N];
  bit se[N];
  int exp_pix;
  int exp_flags;
  int exp_cv;
  int acc_m;
  int q_pix;
  int q_h;
  int q_v;
  bit q_act;
  int o_h;
  int o_v;
  bit o_act;
  bit m_ticked;

  function automatic bit covers(int i, int h, int v);
    return se[i] && sw[i] > 0 && sh[i] > 0
      && h >= sx[i] && h < sx[i] + sw[i]
      && v >= sy[i] && v < sy[i] + sh[i];
  endfunction

  function automatic int paint(int h, int v);
    for (int i = 0; i < N; i++)
      if (covers(i, h, v)) return sc[i];
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          sx[i] = 0; sy[i] = 0; sw[i] = 0;
          sh[i] = 0; sc[i] = 0; se[i] = 0;
        end
        exp_pix = 0; exp_flags = 0; exp_cv = 0;
        acc_m = 0; q_pix = 0; q_act = 0;
        o_act = 0; m_ticked = 0;
      end else begin
        m_ticked = pixel_tick;
        exp_cv = int'(frame_tick);
        if (pixel_tick) begin
          exp_pix = q_pix;
          o_act = q_act; o_h = q_h; o_v = q_v;
          q_act = active;
          q_h = int'(hpos);
          q_v = int'(vpos);
          q_pix = active ? paint(q_h, q_v) : 0;
          if (active && covers(0, q_h, q_v))
            for (int i = 1; i < N; i++)
              if (covers(i, q_h, q_v)) acc_m |= (1 << i);
        end
        if (frame_tick) begin
          exp_flags = acc_m;
          acc_m = 0;
          for (int i = 0; i < N; i++) begin
            sx[i] = $signed(lx[i][CW-1:0]);
            sy[i] = $signed(ly[i][CW-1:0]);
            sw[i] = lw[i]; sh[i] = lh[i];
            sc[i] = lc[i]; se[i] = le[i];
          end
        end
      end
    end
  end

  // captured image of the current frame, keyed v*2048+h
  int img[int];

  initial begin
    forever begin
      @(negedge clk);
      chk("pixel", 32'(pixel), exp_pix);
      chk("coll_flags", 32'(gl.coll_flags), exp_flags);
      chk("coll_valid", 32'(gl.coll_valid), exp_cv);
      if (m_ticked && o_act) img[o_v*2048 + o_h] = int'(pixel);
    end
  end

  function automatic int pix_at(int h, int v);
    if (img.exists(v*2048 + h)) return img[v*2048 + h];
    return -1;
  endfunction

  function automatic int count_col(int c);
    int n = 0;
    foreach (img[k]) if (img[k] == c) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic tick(input bit a, input int h, input int v);
    if ($urandom_range(0, 3) == 0) begin
      pixel_tick = 1'b0;
      step();
    end
    pixel_tick = 1'b1;
    active = a;
    hpos = 10'(h);
    vpos = 10'(v);
    step();
    pixel_tick = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_flags", 32'(gl.coll_flags), 0);
    chk("rst_valid", 32'(gl.coll_valid), 0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input int h0, input int h1,
                           input int v0, input int v1,
                           input int upd_v, input int upd_x,
                           input int rst_v, input int rst_h,
                           output int flags);
    img.delete();
    for (int v = v0; v <= v1; v++) begin
      if (v == upd_v) lx[0] = upd_x;
      for (int h = h0; h <= h1; h++) begin
        if (v == rst_v && h == rst_h) do_reset();
        tick(1'b1, h, v);
      end
      repeat (3) tick(1'b0, 0, v);
    end
    repeat (3) tick(1'b0, 0, 0);
    frame_tick = 1'b1;
    pixel_tick = 1'($urandom_range(0, 1));
    active = 1'b0;
    step();
    frame_tick = 1'b0;
    pixel_tick = 1'b0;
    chk("coll_valid_pulse", 32'(gl.coll_valid), 1);
    flags = int'(gl.coll_flags);
    step();
    chk("coll_valid_drop", 32'(gl.coll_valid), 0);
    repeat (3) tick(1'b0, 0, 0);
  endtask

  task automatic set_obj(input int i, input int x,
                         input int y, input int w,
                         input int h, input int c,
                         input bit e);
    lx[i] = x; ly[i] = y; lw[i] = w;
    lh[i] = h; lc[i] = c; le[i] = e;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("reset_pixel", 32'(pixel), 0);
    chk("reset_flags", 32'(gl.coll_flags), 0);
    chk("reset_valid", 32'(gl.coll_valid), 0);
    rst_n = 1'b1;
    step();

    // ball only; shadows still empty this frame
    set_obj(0, 100, 50, 20, 20, 7, 1);
    run_frame(80, 159, 45, 74, -1, 0, -1, 0, f);
    chk("f0_black", count_col(0), 80 * 30);
    chk("f0_flags", f, 0);

    set_obj(0, 100, 50, 30, 20, 7, 1);
    set_obj(1, 90, 50, 30, 20, 4, 1);
    run_frame(80, 159, 45, 74, -1, 0, -1, 0, f);
    chk("ball_tl", pix_at(100, 50), 7);
    chk("ball_br", pix_at(119, 69), 7);
    chk("ball_left", pix_at(99, 50), 0);
    chk("ball_right", pix_at(120, 50), 0);
    chk("ball_below", pix_at(100, 70), 0);
    chk("ball_above", pix_at(100, 49), 0);
    chk("ball_area", count_col(7), 400);
    chk("f1_flags", f, 0);

    set_obj(0, 119, 50, 20, 20, 7, 1);
    set_obj(1, -10, 50, 20, 20, 4, 1);
    set_obj(2, 138, 50, 20, 20, 2, 1);
    set_obj(3, 125, 55, 0, 10, 1, 1);
    run_frame(80, 159, 45, 74, -1, 0, -1, 0, f);
    chk("prio_red90", pix_at(90, 55), 4);
    chk("prio_red95", pix_at(95, 55), 4);
    chk("prio_bg89", pix_at(89, 55), 0);
    chk("prio_white", pix_at(100, 55), 7);
    chk("prio_white129", pix_at(129, 55), 7);
    chk("prio_bg130", pix_at(130, 55), 0);
    chk("prio_flags", f, 4'b0010);

    set_obj(0, 100, 50, 20, 20, 7, 1);
    le[1] = 1'b0;
    run_frame(0, 159, 45, 74, -1, 0, -1, 0, f);
    chk("clip_h0", pix_at(0, 55), 4);
    chk("clip_h9", pix_at(9, 55), 4);
    chk("clip_h10", pix_at(10, 55), 0);
    chk("coll_px138", pix_at(138, 55), 7);
    chk("coll_px139", pix_at(139, 55), 2);
    chk("coll_px157", pix_at(157, 55), 2);
    chk("coll_px158", pix_at(158, 55), 0);
    chk("zero_w_hidden", pix_at(125, 56), 7);
    chk("zero_w_none", count_col(1), 0);
    chk("coll_flags_hit", f, 4'b0100);

    // live x moves at line 60; shadow keeps 100
    run_frame(80, 159, 45, 74, 60, 300, -1, 0, f);
    chk("mid_old_top", pix_at(100, 50), 7);
    chk("mid_old_low", pix_at(100, 65), 7);
    chk("coll_flags_clr", f, 0);

    run_frame(80, 329, 45, 66, -1, 0, 60, 310, f);
    chk("moved_new", pix_at(300, 55), 7);
    chk("moved_old", pix_at(100, 55), 0);
    chk("post_rst_blk", pix_at(300, 62), 0);
    chk("post_rst_flags", f, 0);

    run_frame(280, 329, 45, 74, -1, 0, -1, 0, f);
    chk("recover", pix_at(300, 55), 7);
    chk("recover_flags", f, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++)
        set_obj(i, $urandom_range(60, 170),
                $urandom_range(40, 80),
                $urandom_range(0, 40),
                $urandom_range(0, 30),
                $urandom_range(0, 7),
                1'($urandom_range(0, 3) != 0));
      run_frame(80, 159, 45, 74, -1, 0, -1, 0, f);
    end
    run_frame(80, 159, 45, 74, -1, 0, -1, 0, f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
